multicycle_control_unit: RTL and testbench

Multicycle control FSM for the RV64I datapath. It sequences instruction fetch, decode, execute, memory access and write-back over the shared single-port memory, ALU, register file and immediate generator. It drives every mux select and write strobe in the datapath, and handshakes with memory through `memReady`. It supports R-type ALU, I-type ALU, loads, stores, and `beq`/`bne`. Any other opcode halts the core.

---
 rtl/riscv_ctrl_pkg.sv | 55 +++++
 rtl/multicycle_control_unit_if.sv | 32 +++
 rtl/control_signal_decoder.sv | 71 +++++++
 rtl/multicycle_control_unit.sv | 68 ++++++
 tb/tb_multicycle_control_unit.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV64I multicycle core: FSM states, opcodes,
// datapath select codes and the bundled control word.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd6,
    S_WB_ALU = 4'd7,
    S_WB_MEM = 4'd8,
    S_BRANCH = 4'd9,
    S_HALT   = 4'd10
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS1   = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef struct packed {
    logic       memRead;
    logic       memWrite;
    logic       memAddrSrc;
    logic       irWrite;
    logic       pcWrite;
    logic       pcSrc;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic       regWrite;
    logic       memToReg;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath/memory bundle. master = control unit.
interface multicycle_control_unit_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       aluZero;
  logic       memReady;
  logic       memRead;
  logic       memWrite;
  logic       memAddrSrc;
  logic       irWrite;
  logic       pcWrite;
  logic       pcSrc;
  logic [1:0] aluSrcA;
  logic [1:0] aluSrcB;
  logic [1:0] aluOp;
  logic       regWrite;
  logic       memToReg;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, funct3, aluZero, memReady,
    output memRead, memWrite, memAddrSrc, irWrite, pcWrite, pcSrc,
           aluSrcA, aluSrcB, aluOp, regWrite, memToReg, illegal, state
  );

  modport slave (
    output opcode, funct3, aluZero, memReady,
    input  memRead, memWrite, memAddrSrc, irWrite, pcWrite, pcSrc,
           aluSrcA, aluSrcB, aluOp, regWrite, memToReg, illegal, state
  );
endinterface

// File: rtl/control_signal_decoder.sv
// Combinational state -> control word map. Moore except FETCH strobes
// (gated by memReady) and the branch pcWrite (gated by aluZero).
module control_signal_decoder
  import riscv_ctrl_pkg::*;
(
  input  state_t     state_i,
  input  logic [2:0] funct3_i,
  input  logic       aluZero_i,
  input  logic       memReady_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.memRead = 1'b1;
        ctrl_o.aluSrcA = SRCA_PC;
        ctrl_o.aluSrcB = SRCB_FOUR;
        ctrl_o.aluOp   = ALU_ADD;
        ctrl_o.irWrite = memReady_i;
        ctrl_o.pcWrite = memReady_i;
      end
      // Branch target (OldPC + imm) lands in ALUOut for use by BRANCH.
      S_DECODE: begin
        ctrl_o.aluSrcA = SRCA_OLDPC;
        ctrl_o.aluSrcB = SRCB_IMM;
        ctrl_o.aluOp   = ALU_ADD;
      end
      S_EXEC_R: begin
        ctrl_o.aluSrcA = SRCA_RS1;
        ctrl_o.aluSrcB = SRCB_RS2;
        ctrl_o.aluOp   = ALU_FUNCT;
      end
      S_EXEC_I: begin
        ctrl_o.aluSrcA = SRCA_RS1;
        ctrl_o.aluSrcB = SRCB_IMM;
        ctrl_o.aluOp   = ALU_FUNCT;
      end
      S_ADDR: begin
        ctrl_o.aluSrcA = SRCA_RS1;
        ctrl_o.aluSrcB = SRCB_IMM;
        ctrl_o.aluOp   = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl_o.memRead    = 1'b1;
        ctrl_o.memAddrSrc = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.memWrite   = 1'b1;
        ctrl_o.memAddrSrc = 1'b1;
      end
      S_WB_ALU: ctrl_o.regWrite = 1'b1;
      S_WB_MEM: begin
        ctrl_o.regWrite = 1'b1;
        ctrl_o.memToReg = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.aluSrcA = SRCA_RS1;
        ctrl_o.aluSrcB = SRCB_RS2;
        ctrl_o.aluOp   = ALU_SUB;
        ctrl_o.pcSrc   = 1'b1;
        ctrl_o.pcWrite = ((funct3_i == F3_BEQ) &&  aluZero_i) ||
                         ((funct3_i == F3_BNE) && !aluZero_i);
      end
      S_HALT:  ctrl_o.illegal = 1'b1;
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV64I control FSM: state register + next-state logic; the
// control word comes from control_signal_decoder and is zeroed in reset.
module multicycle_control_unit
  import riscv_ctrl_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  multicycle_control_unit_if.master  bus
);

  state_t state_q, state_d;
  ctrl_t  dec_ctrl, ctrl;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (bus.memReady) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_R:               state_d = S_EXEC_R;
          OP_IMM:             state_d = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_d = S_ADDR;
          OP_BRANCH:          state_d = (bus.funct3 == F3_BEQ || bus.funct3 == F3_BNE)
                                        ? S_BRANCH : S_HALT;
          default:            state_d = S_HALT;
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
      S_ADDR:   state_d = (bus.opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: if (bus.memReady) state_d = S_WB_MEM;
      S_MEM_WR: if (bus.memReady) state_d = S_FETCH;
      S_WB_ALU, S_WB_MEM, S_BRANCH: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_HALT;
    endcase
  end

  control_signal_decoder u_dec (
    .state_i    (state_q),
    .funct3_i   (bus.funct3),
    .aluZero_i  (bus.aluZero),
    .memReady_i (bus.memReady),
    .ctrl_o     (dec_ctrl)
  );

  // Reset silences every output in the same cycle, before the edge lands.
  assign ctrl = reset ? '0 : dec_ctrl;

  assign bus.memRead    = ctrl.memRead;
  assign bus.memWrite   = ctrl.memWrite;
  assign bus.memAddrSrc = ctrl.memAddrSrc;
  assign bus.irWrite    = ctrl.irWrite;
  assign bus.pcWrite    = ctrl.pcWrite;
  assign bus.pcSrc      = ctrl.pcSrc;
  assign bus.aluSrcA    = ctrl.aluSrcA;
  assign bus.aluSrcB    = ctrl.aluSrcB;
  assign bus.aluOp      = ctrl.aluOp;
  assign bus.regWrite   = ctrl.regWrite;
  assign bus.memToReg   = ctrl.memToReg;
  assign bus.illegal    = ctrl.illegal;
  assign bus.state      = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Cycle-by-cycle vector bench for multicycle_control_unit.
module tb_multicycle_control_unit;
  import riscv_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  multicycle_control_unit_if bus();

  multicycle_control_unit dut (.clk(clk), .reset(reset), .bus(bus.master));

  always #5 clk = ~clk;

  // Output word: rd wr as ir pw ps A[1:0] B[1:0] op[1:0] rw mr il
  localparam logic [14:0] O_ZERO       = 15'b0;
  localparam logic [14:0] O_FETCH_RDY  = 15'b1_0_0_1_1_0_00_01_00_0_0_0;
  localparam logic [14:0] O_FETCH_WAIT = 15'b1_0_0_0_0_0_00_01_00_0_0_0;
  localparam logic [14:0] O_DEC        = 15'b0_0_0_0_0_0_10_10_00_0_0_0;
  localparam logic [14:0] O_EXR        = 15'b0_0_0_0_0_0_01_00_10_0_0_0;
  localparam logic [14:0] O_EXI        = 15'b0_0_0_0_0_0_01_10_10_0_0_0;
  localparam logic [14:0] O_ADDR       = 15'b0_0_0_0_0_0_01_10_00_0_0_0;
  localparam logic [14:0] O_MRD        = 15'b1_0_1_0_0_0_00_00_00_0_0_0;
  localparam logic [14:0] O_MWR        = 15'b0_1_1_0_0_0_00_00_00_0_0_0;
  localparam logic [14:0] O_WBA        = 15'b0_0_0_0_0_0_00_00_00_1_0_0;
  localparam logic [14:0] O_WBM        = 15'b0_0_0_0_0_0_00_00_00_1_1_0;
  localparam logic [14:0] O_BR_T       = 15'b0_0_0_0_1_1_01_00_01_0_0_0;
  localparam logic [14:0] O_BR_N       = 15'b0_0_0_0_0_1_01_00_01_0_0_0;
  localparam logic [14:0] O_HALT       = 15'b0_0_0_0_0_0_00_00_00_0_0_1;

  localparam logic [6:0] OP_BAD = 7'b1111111;

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic [2:0] f3;
    logic       z;
    logic       rdy;
    logic [3:0] st;
    logic [14:0] o;
    string      nm;
  } vec_t;

  vec_t tv[$];
  int ntot = 0;
  int npass = 0;

  task automatic add(input logic r, input logic [6:0] op, input logic [2:0] f3,
                     input logic z, input logic rdy, input logic [3:0] st,
                     input logic [14:0] o, input string nm);
    vec_t v;
    v.rst = r; v.op = op; v.f3 = f3; v.z = z; v.rdy = rdy;
    v.st = st; v.o = o; v.nm = nm;
    tv.push_back(v);
  endtask

  // Drive one cycle of inputs, compare at the falling edge, then step.
  task automatic cyc(input logic r, input logic [6:0] op, input logic [2:0] f3,
                     input logic z, input logic rdy, input logic [3:0] st,
                     input logic [14:0] o, input string nm);
    logic [14:0] got;
    reset        = r;
    bus.opcode   = op;
    bus.funct3   = f3;
    bus.aluZero  = z;
    bus.memReady = rdy;
    @(negedge clk);
    got = {bus.memRead, bus.memWrite, bus.memAddrSrc, bus.irWrite, bus.pcWrite,
           bus.pcSrc, bus.aluSrcA, bus.aluSrcB, bus.aluOp, bus.regWrite,
           bus.memToReg, bus.illegal};
    ntot++;
    if (bus.state === st) npass++;
    else $display("FAIL %s state: got %0d want %0d", nm, bus.state, st);
    ntot++;
    if (got === o) npass++;
    else $display("FAIL %s outputs: got %b want %b", nm, got, o);
    ntot++;
    if (!(bus.memRead === 1'b1 && bus.memWrite === 1'b1)) npass++;
    else $display("FAIL %s rd_wr_excl: got rd=%b wr=%b want not both", nm,
                  bus.memRead, bus.memWrite);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.opcode = OP_IMM; bus.funct3 = 3'b000; bus.aluZero = 1'b0; bus.memReady = 1'b0;
    @(posedge clk);
    #1;

    add(1, OP_IMM, 3'b000, 0, 1, S_FETCH,  O_ZERO,       "reset_hold");
    // addi x1,x0,2 : 4 cycles
    add(0, OP_IMM, 3'b000, 0, 1, S_FETCH,  O_FETCH_RDY,  "addi_fetch");
    add(0, OP_IMM, 3'b000, 0, 1, S_DECODE, O_DEC,        "addi_decode");
    add(0, OP_IMM, 3'b000, 0, 1, S_EXEC_I, O_EXI,        "addi_exec");
    add(0, OP_IMM, 3'b000, 0, 1, S_WB_ALU, O_WBA,        "addi_wb");
    // R-type with one fetch wait; memReady in EXEC_R is ignored
    add(0, OP_R,   3'b000, 0, 0, S_FETCH,  O_FETCH_WAIT, "r_fetch_wait");
    add(0, OP_R,   3'b000, 0, 1, S_FETCH,  O_FETCH_RDY,  "r_fetch");
    add(0, OP_R,   3'b000, 0, 1, S_DECODE, O_DEC,        "r_decode");
    add(0, OP_R,   3'b000, 1, 1, S_EXEC_R, O_EXR,        "r_exec");
    add(0, OP_R,   3'b000, 0, 0, S_WB_ALU, O_WBA,        "r_wb");
    // lw with 2 wait cycles: 7 cycles
    add(0, OP_LOAD, 3'b010, 0, 1, S_FETCH,  O_FETCH_RDY, "lw_fetch");
    add(0, OP_LOAD, 3'b010, 0, 1, S_DECODE, O_DEC,       "lw_decode");
    add(0, OP_LOAD, 3'b010, 0, 0, S_ADDR,   O_ADDR,      "lw_addr");
    add(0, OP_LOAD, 3'b010, 0, 0, S_MEM_RD, O_MRD,       "lw_wait1");
    add(0, OP_LOAD, 3'b010, 0, 0, S_MEM_RD, O_MRD,       "lw_wait2");
    add(0, OP_LOAD, 3'b010, 0, 1, S_MEM_RD, O_MRD,       "lw_rdy");
    add(0, OP_LOAD, 3'b010, 0, 1, S_WB_MEM, O_WBM,       "lw_wb");
    // sw with one wait
    add(0, OP_STORE, 3'b010, 0, 1, S_FETCH,  O_FETCH_RDY, "sw_fetch");
    add(0, OP_STORE, 3'b010, 0, 1, S_DECODE, O_DEC,       "sw_decode");
    add(0, OP_STORE, 3'b010, 0, 1, S_ADDR,   O_ADDR,      "sw_addr");
    add(0, OP_STORE, 3'b010, 0, 0, S_MEM_WR, O_MWR,       "sw_wait");
    add(0, OP_STORE, 3'b010, 0, 1, S_MEM_WR, O_MWR,       "sw_rdy");
    // branches: 3 cycles each
    add(0, OP_BRANCH, F3_BEQ, 1, 1, S_FETCH,  O_FETCH_RDY, "beq_z1_fetch");
    add(0, OP_BRANCH, F3_BEQ, 1, 1, S_DECODE, O_DEC,       "beq_z1_decode");
    add(0, OP_BRANCH, F3_BEQ, 1, 1, S_BRANCH, O_BR_T,      "beq_z1_taken");
    add(0, OP_BRANCH, F3_BNE, 1, 1, S_FETCH,  O_FETCH_RDY, "bne_z1_fetch");
    add(0, OP_BRANCH, F3_BNE, 1, 1, S_DECODE, O_DEC,       "bne_z1_decode");
    add(0, OP_BRANCH, F3_BNE, 1, 1, S_BRANCH, O_BR_N,      "bne_z1_not");
    add(0, OP_BRANCH, F3_BNE, 0, 1, S_FETCH,  O_FETCH_RDY, "bne_z0_fetch");
    add(0, OP_BRANCH, F3_BNE, 0, 1, S_DECODE, O_DEC,       "bne_z0_decode");
    add(0, OP_BRANCH, F3_BNE, 0, 1, S_BRANCH, O_BR_T,      "bne_z0_taken");
    add(0, OP_BRANCH, F3_BEQ, 0, 1, S_FETCH,  O_FETCH_RDY, "beq_z0_fetch");
    add(0, OP_BRANCH, F3_BEQ, 0, 1, S_DECODE, O_DEC,       "beq_z0_decode");
    add(0, OP_BRANCH, F3_BEQ, 0, 1, S_BRANCH, O_BR_N,      "beq_z0_not");
    // branch opcode with unsupported funct3 halts
    add(0, OP_BRANCH, 3'b010, 0, 1, S_FETCH,  O_FETCH_RDY, "blt_fetch");
    add(0, OP_BRANCH, 3'b010, 0, 1, S_DECODE, O_DEC,       "blt_decode");
    add(0, OP_BRANCH, 3'b010, 0, 1, S_HALT,   O_HALT,      "blt_halt");
    add(1, OP_BRANCH, 3'b010, 0, 1, S_FETCH,  O_ZERO,      "blt_reset");

    foreach (tv[i])
      cyc(tv[i].rst, tv[i].op, tv[i].f3, tv[i].z, tv[i].rdy, tv[i].st, tv[i].o, tv[i].nm);

    // Illegal opcode: HALT sticks for 20 cycles whatever the inputs do
    cyc(0, OP_BAD, 3'b000, 0, 1, S_FETCH,  O_FETCH_RDY, "bad_fetch");
    cyc(0, OP_BAD, 3'b000, 0, 1, S_DECODE, O_DEC,       "bad_decode");
    for (int i = 0; i < 20; i++)
      cyc(0, OP_BAD, 3'(i), 1'(i % 2), 1'(i % 3 == 0), S_HALT, O_HALT, "halt_hold");
    cyc(1, OP_BAD, 3'b000, 0, 1, S_FETCH, O_ZERO,       "halt_reset");
    cyc(0, OP_BAD, 3'b000, 0, 0, S_FETCH, O_FETCH_WAIT, "halt_recover");

    // Reset in the middle of a MEM_RD wait drops the request
    cyc(0, OP_LOAD, 3'b010, 0, 1, S_FETCH,  O_FETCH_RDY,  "rst_lw_fetch");
    cyc(0, OP_LOAD, 3'b010, 0, 1, S_DECODE, O_DEC,        "rst_lw_decode");
    cyc(0, OP_LOAD, 3'b010, 0, 0, S_ADDR,   O_ADDR,       "rst_lw_addr");
    cyc(0, OP_LOAD, 3'b010, 0, 0, S_MEM_RD, O_MRD,        "rst_lw_wait");
    cyc(1, OP_LOAD, 3'b010, 0, 0, S_FETCH,  O_ZERO,       "rst_mid_wait");
    cyc(0, OP_LOAD, 3'b010, 0, 0, S_FETCH,  O_FETCH_WAIT, "rst_refetch");
    cyc(0, OP_LOAD, 3'b010, 0, 1, S_FETCH,  O_FETCH_RDY,  "rst_refetch_rdy");

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
